// File: rtl/pulse_pair_gen_if.sv
// -----------------------------------------------------------------------------
// pulse_pair_gen_if
// Control/status bundle between a controller and pulse_pair_gen.
//   Controller -> generator : en, start, stop, dly, pw, period, count
//   Generator -> controller : x1, x2, busy, done, err, pair_idx
// The controller side uses the master modport and the generator uses slave.
// -----------------------------------------------------------------------------
interface pulse_pair_gen_if #(
  parameter int DLY_W = 8,
  parameter int PW_W  = 8,
  parameter int PER_W = 16,
  parameter int CNT_W = 8
) ();

  logic             en;        // global enable, low freezes the generator
  logic             start;     // run request, taken in IDLE only
  logic             stop;      // graceful stop request during a run
  logic [DLY_W-1:0] dly;       // two's complement x2-relative-to-x1 delay
  logic [PW_W-1:0]  pw;        // pulse width in cycles
  logic [PER_W-1:0] period;    // pair repetition period in cycles
  logic [CNT_W-1:0] count;     // number of pairs, 0 = until stop

  logic             x1;        // channel-1 pulse
  logic             x2;        // channel-2 pulse
  logic             busy;      // run in progress
  logic             done;      // one-cycle end-of-run pulse
  logic             err;       // one-cycle rejected-start pulse
  logic [CNT_W-1:0] pair_idx;  // index of the pair being emitted

  modport master (
    output en, start, stop, dly, pw, period, count,
    input  x1, x2, busy, done, err, pair_idx
  );

  modport slave (
    input  en, start, stop, dly, pw, period, count,
    output x1, x2, busy, done, err, pair_idx
  );

endinterface

// File: rtl/pulse_pair_gen.sv
// -----------------------------------------------------------------------------
// pulse_pair_gen
// Two-channel pulse-pair generator driving the x1/x2 inputs of the
// coincidence-detection array with a cycle-exact inter-channel delay.
//
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : pulse_pair_gen_if.slave (config/handshake in, pulses/status out)
//
// A run is a sequence of pairs. Inside a pair the phase counter r_t walks
// 0..period-1; the leading channel is high for t in [0, pw-1] and the lagging
// channel for t in [mag, mag+pw-1]. x1/x2 are registered from that decode, so
// they appear one cycle after the phase that produces them. To let the last
// lagging pulse leave the output register, a run ends with one tail cycle
// (still busy, no pulses) before returning to IDLE with done.
// -----------------------------------------------------------------------------
module pulse_pair_gen #(
  parameter int DLY_W = 8,
  parameter int PW_W  = 8,
  parameter int PER_W = 16,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  pulse_pair_gen_if.slave  bus
);

  // Wide enough for mag+pw and period with a spare bit, so the validity
  // compare and the lagging-window bound can never overflow.
  localparam int CMP_W = ((PER_W > DLY_W + 1) ? PER_W : DLY_W + 1) + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Registered state
  state_t           r_state;
  logic [PER_W-1:0] r_t;
  logic [CNT_W-1:0] r_idx;
  logic             r_stop;
  logic             r_tail;
  logic             r_x1;
  logic             r_x2;
  logic             r_done;
  logic             r_err;

  // Configuration captured on an accepted start
  logic [PW_W-1:0]  r_pw;
  logic [PER_W-1:0] r_period;
  logic [CNT_W-1:0] r_count;
  logic [DLY_W-1:0] r_mag;
  logic             r_neg;

  // Next-state values
  state_t           w_state_nxt;
  logic [PER_W-1:0] w_t_nxt;
  logic [CNT_W-1:0] w_idx_nxt;
  logic             w_stop_nxt;
  logic             w_tail_nxt;
  logic             w_x1_nxt;
  logic             w_x2_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_load;

  // Start-time configuration check on the live inputs. |dly| as an unsigned
  // DLY_W-bit value: the most-negative delay maps to 2^(DLY_W-1) exactly.
  logic [DLY_W-1:0] w_in_mag;
  logic [CMP_W-1:0] w_in_sum;
  logic             w_cfg_ok;

  assign w_in_mag = bus.dly[DLY_W-1] ? (~bus.dly + DLY_W'(1)) : bus.dly;
  assign w_in_sum = CMP_W'(w_in_mag) + CMP_W'(bus.pw);
  assign w_cfg_ok = (bus.pw != '0) && (bus.period != '0) &&
                    (w_in_sum <= CMP_W'(bus.period));

  // Phase decode against the captured configuration
  logic w_lead;
  logic w_lag;
  logic w_wrap;
  logic w_last;

  assign w_lead = CMP_W'(r_t) < CMP_W'(r_pw);
  assign w_lag  = (CMP_W'(r_t) >= CMP_W'(r_mag)) &&
                  (CMP_W'(r_t) <  CMP_W'(r_mag) + CMP_W'(r_pw));
  assign w_wrap = (r_t == r_period - PER_W'(1));
  // A stop arriving on the wrap cycle itself still ends after this pair.
  assign w_last = ((r_count != '0) && (r_idx == r_count - CNT_W'(1))) ||
                  r_stop || bus.stop;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_idx_nxt   = r_idx;
    w_stop_nxt  = r_stop;
    w_tail_nxt  = r_tail;
    w_x1_nxt    = r_x1;
    w_x2_nxt    = r_x2;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;

    // Stop is remembered even while frozen by en=0.
    if (r_state == S_RUN && !r_tail) begin
      w_stop_nxt = r_stop | bus.stop;
    end

    if (bus.en) begin
      w_x1_nxt = 1'b0;
      w_x2_nxt = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_cfg_ok) begin
              w_load      = 1'b1;
              w_state_nxt = S_RUN;
              w_t_nxt     = '0;
              w_idx_nxt   = '0;
              w_stop_nxt  = 1'b0;   // a simultaneous stop is discarded
              w_tail_nxt  = 1'b0;
            end else begin
              w_err_nxt   = 1'b1;
            end
          end
        end

        S_RUN: begin
          if (r_tail) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_idx_nxt   = '0;
            w_t_nxt     = '0;
            w_tail_nxt  = 1'b0;
            w_stop_nxt  = 1'b0;
          end else begin
            w_x1_nxt = r_neg ? w_lag  : w_lead;
            w_x2_nxt = r_neg ? w_lead : w_lag;
            if (w_wrap) begin
              w_t_nxt = '0;
              if (w_last) begin
                w_tail_nxt = 1'b1;
              end else begin
                w_idx_nxt  = r_idx + CNT_W'(1);
              end
            end else begin
              w_t_nxt = r_t + PER_W'(1);
            end
          end
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_idx   <= '0;
      r_stop  <= 1'b0;
      r_tail  <= 1'b0;
      r_x1    <= 1'b0;
      r_x2    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      r_idx   <= w_idx_nxt;
      r_stop  <= w_stop_nxt;
      r_tail  <= w_tail_nxt;
      r_x1    <= w_x1_nxt;
      r_x2    <= w_x2_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // NOTE: the configuration registers are reset too; they are few and a
  // known value keeps the idle decode deterministic after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pw     <= '0;
      r_period <= '0;
      r_count  <= '0;
      r_mag    <= '0;
      r_neg    <= 1'b0;
    end else if (w_load) begin
      r_pw     <= bus.pw;
      r_period <= bus.period;
      r_count  <= bus.count;
      r_mag    <= w_in_mag;
      r_neg    <= bus.dly[DLY_W-1];
    end
  end

  assign bus.x1       = r_x1;
  assign bus.x2       = r_x2;
  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.pair_idx = r_idx;

endmodule

// File: doc/pulse_pair_gen.md
# pulse_pair_gen

Programmable two-channel pulse-pair generator that drives the x1/x2 inputs of the coincidence-detection array (CDA) with a known, cycle-exact inter-channel delay. It is the transmit side of the x1/x2 timing interface: the CDA measures the delay between x1 and x2, and this block produces pulse pairs whose delay, width, repetition period and count are set by the controller. It is used for on-chip calibration and self-test of the CDA delay chain, and as a bench stimulus source.

## Interface
- DLY_W, 8: width of signed delay field (two's complement)
- PW_W, 8: width of pulse-width field
- PER_W, 16: width of period field
- CNT_W, 8: width of pair-count field and pair index
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous and active-high
- en  input  1  global enable; low freezes all counters and outputs (holds state)
- start  input  1  request; sampled only in IDLE with en=1
- stop  input  1  graceful stop request; sampled in RUN
- dly  input  DLY_W  signed x2-relative-to-x1 delay in cycles (>0: x2 lags, <0: x2 leads)
- pw  input  PW_W  pulse width in cycles
- period  input  PER_W  pair repetition period in cycles
- count  input  CNT_W  number of pairs; 0 = continuous until stop
- x1  output  1  channel-1 pulse, registered
- x2  output  1  channel-2 pulse, registered
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at end of run
- err  output  1  one-cycle pulse on rejected start
- pair_idx  output  CNT_W  index of pair currently being emitted

## Operation
- States: IDLE, RUN. Reset (async): state=IDLE; x1, x2, busy, done, err = 0; pair_idx = 0; internal counters = 0.
- IDLE, start=1, en=1: latch dly/pw/period/count; compute mag=|dly| as DLY_W-bit unsigned (most-negative dly gives 2^(DLY_W-1), no overflow).
- Config invalid when pw==0, period==0, or mag+pw > period (compare in max(PER_W,DLY_W+1)+1 bits). Invalid: err=1 for one cycle, stay IDLE, outputs unchanged.
- Valid: go RUN, phase counter t=0, pair_idx=0, busy=1.
- RUN: t counts 0..period-1 and wraps. Leading channel (x1 if dly>=0, else x2) high for t in [0, pw-1]; lagging channel high for t in [mag, mag+pw-1]. dly=0: x1 and x2 identical.
- Wrap (t==period-1): if count!=0 and pair_idx==count-1, or stop latched: go IDLE, done=1 one cycle, busy=0, pair_idx=0. Else pair_idx+=1 (wraps modulo 2^CNT_W when count=0).
- stop: latched when seen in RUN; current pair always completes. stop in IDLE ignored. stop and start together in IDLE: start wins, stop discarded.
- start in RUN ignored; config inputs ignored outside the start-accept cycle.
- en=0: t, pair_idx, state, x1, x2 hold; done/err not generated; a stop seen while en=0 is still latched.
- Reset mid-run: x1/x2 drop immediately (async), no done.

## Timing
- start sampled at end of cycle c: busy=1 from cycle c+1; t=0 in cycle c+1.
- x1/x2 registered from t decode: leading pulse high cycles c+2..c+1+pw; lagging pulse high cycles c+2+mag..c+1+mag+pw.
- Pair k leading edge at cycle c+2+k*period.
- Finite run of N pairs: done=1 and busy=0 in cycle c+2+N*period; a new start is accepted in that same cycle.
- err asserted in cycle c+1 on reject.

## Test plan
- dly=+3, pw=2, period=10, count=2 -> x1 high c+2..c+3 and c+12..c+13; x2 high c+5..c+6 and c+15..c+16; done at c+22; pair_idx 0 then 1.
- dly=-4 (DLY_W=8), pw=1, period=6, count=1 -> x2 high c+2, x1 high c+6, done at c+8.
- dly=-128, pw=1, period=128 -> err pulse c+1, busy stays 0; then period=129 -> accepted, x1 high at c+130.
- count=0, period=5, pw=1, dly=0, stop in mid-pair 3 -> x1=x2 every 5 cycles, pair 3 completes, done at end of pair 3.
- en low for 7 cycles mid-pulse -> x1/x2, t, pair_idx frozen; all later edges shifted by exactly 7 cycles.
- rst asserted mid-pulse -> x1/x2/busy low same cycle without clock edge; no done; fresh start behaves as first run.
